hbridge_sequencer: RTL and testbench
====================================

HBRIDGE_SEQUENCER -- requirements
Module: hbridge_sequencer

Interface
REQ-001 Parameter PERIOD_CYCLES, default 2500, PWM period in clk cycles (20 kHz at 50 MHz).
REQ-002 Parameter DEAD_CYCLES, default 50, dead time in clk cycles with both switches of one half-bridge off.
REQ-003 Parameter REVERSE_HOLD, default 25000, all-off coast length in clk cycles on a direction change.
REQ-004 Parameter DUTY_W, default 12, width of duty; PERIOD_CYCLES SHALL be at most 2^DUTY_W-1.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  1 = bridge may drive; 0 = force idle.
REQ-008 shutdown  input  1  kill request; 1 = force idle, same priority as enable=0.
REQ-009 cmd_valid  input  1  new command offered.
REQ-010 cmd_ready  output  1  command slot free.
REQ-011 cmd_duty  input  DUTY_W  high-side on-time in cycles per period.
REQ-012 cmd_dir  input  1  0 = forward, 1 = reverse.
REQ-013 hb_out  output  4  {fwd_top, fwd_bot, rev_top, rev_bot} gate drives, registered.
REQ-014 coasting  output  1  1 while in COAST.
REQ-015 period_start  output  1  one-cycle pulse when the period counter is 0 in DRIVE.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE and COAST.
REQ-017 Handshake: a command is accepted on any cycle with cmd_valid & cmd_ready.
REQ-018 Acceptance loads a pending register {duty, dir} and drops cmd_ready to 0 on the next cycle.
REQ-019 cmd_ready SHALL return to 1 the cycle after the pending command is applied.
REQ-020 Apply point: the pending command is applied when the period counter is PERIOD_CYCLES-1, or on the first cycle in IDLE with enable=1 and shutdown=0.
REQ-021 Active {duty_l, dir_l} SHALL never change at any other time.
REQ-022 Duty clamp: duty_l = min(cmd_duty, PERIOD_CYCLES).
REQ-023 IDLE -> DRIVE requires enable=1, shutdown=0 and a pending or already-active command; the period counter starts at 0.
REQ-024 The period counter counts 0..PERIOD_CYCLES-1 and wraps to 0 in DRIVE; it is held at 0 outside DRIVE.
REQ-025 Driven side X = fwd when dir_l=0, rev when dir_l=1; the other side is Y.
REQ-026 In DRIVE, Y_bot=1 and Y_top=0 continuously.
REQ-027 Desired phase on = (counter < duty_l); duty 0 gives a steady low-side brake and duty PERIOD_CYCLES gives a steady high side.
REQ-028 In DRIVE, X_top = on & dead_done and X_bot = !on & dead_done.
REQ-029 Each change of the desired phase loads the dead counter with DEAD_CYCLES and clears dead_done.
REQ-030 A phase change while the dead counter is running SHALL reload it.
REQ-031 Invariant: X_top&X_bot and Y_top&Y_bot SHALL never be 1 in any cycle.
REQ-032 Direction change: a new dir != dir_l applied in DRIVE enters COAST with hb_out=0000 for REVERSE_HOLD cycles, then enters DRIVE with the new dir at counter 0.
REQ-033 On entry to DRIVE from COAST, dead_done SHALL start cleared, giving DEAD_CYCLES all-off on X.
REQ-034 A command received during COAST is accepted but applied only at the first period boundary after COAST exits.
REQ-035 Kill: enable=0 or shutdown=1 in any state forces IDLE, and hb_out=0000 from the next rising edge.
REQ-036 A kill SHALL not clear the pending register or the active command.
REQ-037 Leaving IDLE after a kill SHALL always pass through DEAD_CYCLES with all outputs off before any switch turns on.
REQ-038 Simultaneous cmd accept and apply point: the accepted command is applied at the next apply point, not the current one.
REQ-039 All outputs SHALL be registered, with no combinational path from inputs to hb_out.

Reset
REQ-040 Reset asserted: state IDLE, hb_out=0000, cmd_ready=1, coasting=0, period_start=0, counters 0, pending empty.
REQ-041 Reset asserted: active duty_l=0, dir_l=0.
REQ-042 Reset deassertion mid-operation SHALL resume from IDLE only.

Verification (bench with PERIOD_CYCLES=100, DEAD_CYCLES=5, REVERSE_HOLD=200)
REQ-043 enable=1, cmd duty=40 dir=0 -> per period: fwd_top=1 for 35 cycles, 5 off, fwd_bot=1 for 55 cycles, 5 off, and rev_bot=1 throughout.
REQ-044 Sweep duty 0, 3, 100, 150 -> 0 gives steady fwd_bot=1; 3 gives no top pulse (dead reload); 100 and 150 give fwd_top=1 after the initial 5-cycle dead time; no shoot-through ever.
REQ-045 In DRIVE duty=40 dir=0, issue dir=1 mid-period -> forward continues to the period end, then 0000 for 200 cycles with coasting=1, then rev_top/fwd_bot pattern after 5 dead cycles.
REQ-046 shutdown pulse of 1 cycle mid-on-phase -> hb_out=0000 on the next edge, IDLE; on release, 5 all-off cycles then the same duty/dir resume from counter 0.
REQ-047 Back-to-back cmd_valid held high -> first accepted, cmd_ready=0 until the period boundary; second accepted the cycle after apply; assert reset mid-period -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/hbridge_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : hbridge_sequencer_if
// Purpose  : Command channel for the H-bridge sequencer. A command is a
//            {duty, dir} pair moved with a valid/ready handshake.
// Signals  : cmd_valid  - command offered (master -> slave)
//            cmd_ready  - command slot free (slave -> master)
//            cmd_duty   - high-side on-time in clk cycles per PWM period
//            cmd_dir    - 0 = forward, 1 = reverse
// Revision : 1.0 - initial release
// ============================================================================
interface hbridge_sequencer_if #(
    parameter int DUTY_W = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_duty,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_duty,
        input  cmd_dir,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/hbridge_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hbridge_sequencer
// Purpose  : PWM sequencer for a full H-bridge with dead-time insertion,
//            coast-on-reversal and kill handling. Commands are buffered in a
//            one-deep pending register and only take effect at a period
//            boundary (or when leaving IDLE).
// Ports    : clk          - single clock, rising edge
//            reset        - asynchronous, active-high
//            enable       - 1 = bridge may drive, 0 = force idle
//            shutdown     - 1 = force idle (same priority as enable=0)
//            cmd          - command channel (slave side)
//            hb_out       - {fwd_top, fwd_bot, rev_top, rev_bot}, registered
//            coasting     - 1 while all switches are held off for a reversal
//            period_start - one-cycle pulse at period counter 0 in DRIVE
// Revision : 1.0 - initial release
// ============================================================================
module hbridge_sequencer #(
    parameter int PERIOD_CYCLES = 2500,
    parameter int DEAD_CYCLES   = 50,
    parameter int REVERSE_HOLD  = 25000,
    parameter int DUTY_W        = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                shutdown,
    hbridge_sequencer_if.slave  cmd,
    output logic [3:0]          hb_out,
    output logic                coasting,
    output logic                period_start
);

    localparam int DEAD_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam int HOLD_W = (REVERSE_HOLD > 1) ? $clog2(REVERSE_HOLD + 1) : 1;

    localparam logic [DUTY_W-1:0] c_period    = DUTY_W'(PERIOD_CYCLES);
    localparam logic [DUTY_W-1:0] c_last      = DUTY_W'(PERIOD_CYCLES - 1);
    localparam logic [DEAD_W-1:0] c_dead      = DEAD_W'(DEAD_CYCLES);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(REVERSE_HOLD - 1);
    localparam logic              c_no_dead   = (DEAD_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_COAST = 2'd2
    } state_t;

    // Registered state
    state_t            r_state;
    logic [DUTY_W-1:0] r_cnt;
    logic [DEAD_W-1:0] r_dead_cnt;
    logic              r_dead_done;
    logic              r_started;     // first dead time after entering DRIVE has elapsed
    logic              r_on;          // desired phase of the previous cycle
    logic [HOLD_W-1:0] r_coast_cnt;
    logic [DUTY_W-1:0] r_duty_l;
    logic              r_dir_l;
    logic              r_act_valid;   // an applied command exists
    logic [DUTY_W-1:0] r_pend_duty;
    logic              r_pend_dir;
    logic              r_cmd_ready;   // 0 doubles as "pending register full"
    logic [3:0]        r_hb;
    logic              r_coasting;
    logic              r_period_start;

    // Next-state values
    state_t            w_state;
    logic [DUTY_W-1:0] w_cnt;
    logic [DEAD_W-1:0] w_dead_cnt;
    logic              w_dead_done;
    logic              w_started;
    logic              w_on;
    logic [HOLD_W-1:0] w_coast_cnt;
    logic [DUTY_W-1:0] w_duty_l;
    logic              w_dir_l;
    logic              w_act_valid;
    logic [DUTY_W-1:0] w_pend_duty;
    logic              w_pend_dir;
    logic              w_cmd_ready;
    logic              w_kill;
    logic              w_pending;
    logic              w_apply;
    logic              w_entering;
    logic              w_xt;
    logic              w_xb;
    logic [3:0]        w_hb;

    always_comb begin
        w_kill      = !enable || shutdown;
        w_pending   = !r_cmd_ready;
        w_state     = r_state;
        w_cnt       = '0;
        w_coast_cnt = r_coast_cnt;
        w_duty_l    = r_duty_l;
        w_dir_l     = r_dir_l;
        w_act_valid = r_act_valid;
        w_pend_duty = r_pend_duty;
        w_pend_dir  = r_pend_dir;
        w_cmd_ready = r_cmd_ready;
        w_apply     = 1'b0;

        // Accept only into an empty slot, so an accept can never coincide
        // with applying that same command.
        if (cmd.cmd_valid && r_cmd_ready) begin
            w_pend_duty = cmd.cmd_duty;
            w_pend_dir  = cmd.cmd_dir;
            w_cmd_ready = 1'b0;
        end

        if (w_kill) begin
            w_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pending || r_act_valid) begin
                        w_state = ST_DRIVE;
                        w_apply = w_pending;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == c_last) begin
                        w_apply = w_pending;
                        if (w_pending && (r_pend_dir != r_dir_l)) begin
                            w_state     = ST_COAST;
                            w_coast_cnt = c_hold_last;
                        end
                    end else begin
                        w_cnt = r_cnt + DUTY_W'(1);
                    end
                end
                ST_COAST: begin
                    if (r_coast_cnt == '0) begin
                        w_state = ST_DRIVE;
                    end else begin
                        w_coast_cnt = r_coast_cnt - HOLD_W'(1);
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end

        if (w_apply) begin
            w_duty_l    = (r_pend_duty > c_period) ? c_period : r_pend_duty;
            w_dir_l     = r_pend_dir;
            w_act_valid = 1'b1;
            w_cmd_ready = 1'b1;
        end

        // Dead-time: every phase change (and every entry into DRIVE) restarts
        // the all-off window on the driven side. Until the first window after
        // entry completes, the opposite low side stays off as well so the
        // bridge leaves IDLE/COAST with every switch off.
        w_entering  = (w_state == ST_DRIVE) && (r_state != ST_DRIVE);
        w_on        = (w_cnt < w_duty_l);
        w_dead_cnt  = r_dead_cnt;
        w_dead_done = r_dead_done;
        w_started   = r_started;
        if (w_state != ST_DRIVE) begin
            w_on        = 1'b0;
            w_dead_cnt  = '0;
            w_dead_done = 1'b0;
            w_started   = 1'b0;
        end else if (w_entering || (w_on != r_on)) begin
            w_dead_cnt  = c_dead;
            w_dead_done = c_no_dead;
            if (w_entering) begin
                w_started = c_no_dead;
            end
        end else if (r_dead_cnt != '0) begin
            w_dead_cnt  = r_dead_cnt - DEAD_W'(1);
            w_dead_done = (r_dead_cnt == DEAD_W'(1));
            w_started   = r_started || w_dead_done;
        end

        w_xt = w_on && w_dead_done;
        w_xb = !w_on && w_dead_done;
        w_hb = w_dir_l ? {1'b0, w_started, w_xt, w_xb}
                       : {w_xt, w_xb, 1'b0, w_started};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_dead_cnt     <= '0;
            r_dead_done    <= 1'b0;
            r_started      <= 1'b0;
            r_on           <= 1'b0;
            r_coast_cnt    <= '0;
            r_duty_l       <= '0;
            r_dir_l        <= 1'b0;
            r_act_valid    <= 1'b0;
            r_pend_duty    <= '0;
            r_pend_dir     <= 1'b0;
            r_cmd_ready    <= 1'b1;
            r_hb           <= 4'b0000;
            r_coasting     <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_cnt          <= w_cnt;
            r_dead_cnt     <= w_dead_cnt;
            r_dead_done    <= w_dead_done;
            r_started      <= w_started;
            r_on           <= w_on;
            r_coast_cnt    <= w_coast_cnt;
            r_duty_l       <= w_duty_l;
            r_dir_l        <= w_dir_l;
            r_act_valid    <= w_act_valid;
            r_pend_duty    <= w_pend_duty;
            r_pend_dir     <= w_pend_dir;
            r_cmd_ready    <= w_cmd_ready;
            r_hb           <= w_hb;
            r_coasting     <= (w_state == ST_COAST);
            r_period_start <= (w_state == ST_DRIVE) && (w_cnt == '0);
        end
    end

    assign hb_out        = r_hb;
    assign coasting      = r_coasting;
    assign period_start  = r_period_start;
    assign cmd.cmd_ready = r_cmd_ready;

endmodule
`default_nettype wire

// File: tb/tb_hbridge_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hbridge_sequencer
// Purpose  : Directed self-checking bench for hbridge_sequencer with
//            PERIOD_CYCLES=100, DEAD_CYCLES=5, REVERSE_HOLD=200.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hbridge_sequencer;

    localparam int P  = 100;
    localparam int D  = 5;
    localparam int H  = 200;
    localparam int DW = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       shutdown;
    logic [3:0] hb_out;
    logic       coasting;
    logic       period_start;

    int n_checks = 0;
    int n_fail   = 0;

    hbridge_sequencer_if #(.DUTY_W(DW)) cmd_if ();

    hbridge_sequencer #(
        .PERIOD_CYCLES (P),
        .DEAD_CYCLES   (D),
        .REVERSE_HOLD  (H),
        .DUTY_W        (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .shutdown     (shutdown),
        .cmd          (cmd_if.slave),
        .hb_out       (hb_out),
        .coasting     (coasting),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check hb_out for n consecutive cycles, advancing one clock after each.
    task automatic run_hb(input string tag, input int n, input logic [3:0] exp);
        for (int i = 0; i < n; i++) begin
            n_checks++;
            assert (hb_out === exp) else begin
                n_fail++;
                $error("FAIL %s +%0d: hb_out observed %b expected %b", tag, i, hb_out, exp);
            end
            tick();
        end
    endtask

    task automatic send(input logic [DW-1:0] duty, input logic dir);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_duty  = duty;
        cmd_if.cmd_dir   = dir;
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b0;
        shutdown         = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_duty  = '0;
        cmd_if.cmd_dir   = 1'b0;
        tick();
        chk("rst_hb",     hb_out,           4'b0000);
        chk("rst_ready",  cmd_if.cmd_ready, 4'd1);
        chk("rst_coast",  coasting,         4'd0);
        chk("rst_pstart", period_start,     4'd0);

        // Forward duty 40 from IDLE
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        send(12'd40, 1'b0);
        tick();
        cmd_if.cmd_valid = 1'b0;
        chk("acc_ready", cmd_if.cmd_ready, 4'd0);
        chk("acc_hb",    hb_out,           4'b0000);
        tick();
        chk("p1_start", period_start,     4'd1);
        chk("p1_ready", cmd_if.cmd_ready, 4'd1);
        run_hb("p1_entry_dead", 5,  4'b0000);
        run_hb("p1_top",        35, 4'b1001);
        run_hb("p1_dead_fall",  5,  4'b0001);
        run_hb("p1_bot",        55, 4'b0101);
        chk("p2_start", period_start, 4'd1);
        run_hb("p2_dead_rise",  5,  4'b0001);
        run_hb("p2_top",        35, 4'b1001);
        chk("p2_mid_pstart", period_start, 4'd0);

        // Duty 3: the falling edge reloads the dead counter, no top pulse
        send(12'd3, 1'b0);
        run_hb("p2_dead_fall", 1, 4'b0001);
        cmd_if.cmd_valid = 1'b0;
        chk("d3_ready_lo", cmd_if.cmd_ready, 4'd0);
        run_hb("p2_dead_fall", 4,  4'b0001);
        run_hb("p2_bot",       55, 4'b0101);
        chk("d3_ready_back", cmd_if.cmd_ready, 4'd1);
        send(12'd0, 1'b0);
        run_hb("d3_dead", 1, 4'b0001);
        cmd_if.cmd_valid = 1'b0;
        run_hb("d3_dead", 7,  4'b0001);
        run_hb("d3_bot",  92, 4'b0101);

        // Duty 0: steady low side
        send(12'd100, 1'b0);
        run_hb("d0_bot", 1, 4'b0101);
        cmd_if.cmd_valid = 1'b0;
        run_hb("d0_bot", 99, 4'b0101);

        // Duty 100: steady high side after one dead window
        send(12'd150, 1'b0);
        run_hb("d100_dead", 1, 4'b0001);
        cmd_if.cmd_valid = 1'b0;
        run_hb("d100_dead", 4,  4'b0001);
        run_hb("d100_top",  95, 4'b1001);

        // Duty 150 clamps to a full period: no phase change at the wrap
        send(12'd40, 1'b0);
        run_hb("d150_top", 1, 4'b1001);
        cmd_if.cmd_valid = 1'b0;
        run_hb("d150_top", 99, 4'b1001);

        // Duty 40 following full-on: high side continues across the wrap
        run_hb("d40_top", 20, 4'b1001);
        send(12'd40, 1'b1);
        run_hb("d40_top", 1, 4'b1001);
        cmd_if.cmd_valid = 1'b0;
        run_hb("d40_top",  19, 4'b1001);
        run_hb("d40_dead", 5,  4'b0001);
        run_hb("d40_bot",  55, 4'b0101);

        // Reversal: 200 coast cycles, then reverse pattern after dead time
        chk("coast_flag",   coasting,         4'd1);
        chk("coast_ready",  cmd_if.cmd_ready, 4'd1);
        chk("coast_pstart", period_start,     4'd0);
        run_hb("coast", 199, 4'b0000);
        chk("coast_last", coasting, 4'd1);
        run_hb("coast", 1, 4'b0000);
        chk("rev_coast_off", coasting,     4'd0);
        chk("rev_start",     period_start, 4'd1);
        run_hb("rev_entry_dead", 5,  4'b0000);
        run_hb("rev_top",        35, 4'b0110);
        run_hb("rev_dead_fall",  5,  4'b0100);
        run_hb("rev_bot",        55, 4'b0101);
        run_hb("rev_dead_rise",  5,  4'b0100);
        run_hb("rev_top2",       10, 4'b0110);

        // One-cycle shutdown mid on-phase
        shutdown = 1'b1;
        run_hb("pre_kill", 1, 4'b0110);
        shutdown = 1'b0;
        chk("kill_hb",     hb_out,       4'b0000);
        chk("kill_pstart", period_start, 4'd0);
        tick();
        chk("resume_start", period_start, 4'd1);
        run_hb("resume_dead", 5,  4'b0000);
        run_hb("resume_top",  35, 4'b0110);

        // Back-to-back commands with cmd_valid held high
        send(12'd40, 1'b1);
        run_hb("b2b_dead", 1, 4'b0100);
        chk("b2b_ready_lo", cmd_if.cmd_ready, 4'd0);
        run_hb("b2b_dead", 4,  4'b0100);
        run_hb("b2b_bot",  54, 4'b0101);
        chk("b2b_hold", cmd_if.cmd_ready, 4'd0);
        run_hb("b2b_bot", 1, 4'b0101);
        chk("b2b_applied", cmd_if.cmd_ready, 4'd1);
        run_hb("b2b_dead2", 1, 4'b0100);
        chk("b2b_second", cmd_if.cmd_ready, 4'd0);
        cmd_if.cmd_valid = 1'b0;
        run_hb("b2b_dead2", 4,  4'b0100);
        run_hb("b2b_top",   10, 4'b0110);

        // Asynchronous reset mid-period
        reset = 1'b1;
        #1;
        chk("async_hb",    hb_out,           4'b0000);
        chk("async_ready", cmd_if.cmd_ready, 4'd1);
        chk("async_coast", coasting,         4'd0);
        tick();
        tick();
        reset = 1'b0;
        run_hb("post_reset_idle", 5, 4'b0000);
        chk("post_reset_pstart", period_start, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
